// File: rtl/game_pkg.sv
// Shared types and defaults for the per-frame game sequencer.
package game_pkg;

  typedef enum logic [1:0] {
    TITLE = 2'd0,
    PLAY  = 2'd1,
    DEAD  = 2'd2
  } mode_t;

  typedef enum logic [2:0] {
    S_TITLE,
    S_CLEAR,
    S_WAIT,
    S_UPD,
    S_CHECK,
    S_DEAD
  } seq_state_t;

  localparam int SLOT_CHAR   = 0;
  localparam int SLOT_ENEMY1 = 1;
  localparam int SLOT_PLAT1  = 2;
  localparam int SLOT_SPARE  = 3;

  localparam int TIMEOUT_DEF     = 1023;
  localparam int DEAD_FRAMES_DEF = 120;

endpackage

// File: rtl/game_sequencer_edge_detect.sv
// Registered edge detector, one-cycle pulses one clock after the edge is sampled.
// POL=0 treats sig as active-low, so rise marks assertion (the falling pin edge).
module edge_detect #(
  parameter bit POL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic lvl;
  logic lvl_q;

  assign lvl = POL ? sig : ~sig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      lvl_q <= lvl;
      rise  <= lvl & ~lvl_q;
      fall  <= ~lvl & lvl_q;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Per-frame game controller: on each VSYNC tick, requests slot updates in order with a timeout,
// then samples the death verdict. All outputs registered; tick -> update_req[0] is 1 Clk.
module game_sequencer
  import game_pkg::*;
#(
  parameter int N_SLOT      = 4,
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int DEAD_FRAMES = DEAD_FRAMES_DEF,
  parameter int SCORE_W     = 16
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_clk,
  input  logic               start_key,
  input  logic               dead_in,
  input  logic [N_SLOT-1:0]  update_done,
  output logic [N_SLOT-1:0]  update_req,
  output logic               soft_reset,
  output mode_t              game_state,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         overrun_cnt,
  output logic [N_SLOT-1:0]  timeout_err
);

  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam int DCNT_W = $clog2(DEAD_FRAMES + 1);
  localparam int SLOT_W = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;

  seq_state_t         state, state_nx;
  logic [SLOT_W-1:0]  slot, slot_nx;
  logic [TMR_W-1:0]   tmr, tmr_nx;
  logic [DCNT_W-1:0]  dcnt, dcnt_nx;
  logic [SCORE_W-1:0] score_nx;
  logic [7:0]         overrun_nx;
  logic [N_SLOT-1:0]  terr_nx, req_nx;
  logic               soft_nx;
  mode_t              mode_nx;
  logic               tick, start_rise;
  logic               vs_release_unused, start_fall_unused;

  // VGA_VS is active-low: its assertion (falling pin edge) is the frame tick.
  edge_detect #(.POL(1'b0)) u_vs_edge (
    .clk(Clk), .rst_n(Reset_n), .sig(frame_clk), .rise(tick), .fall(vs_release_unused)
  );

  edge_detect #(.POL(1'b1)) u_start_edge (
    .clk(Clk), .rst_n(Reset_n), .sig(start_key), .rise(start_rise), .fall(start_fall_unused)
  );

  always_comb begin
    state_nx   = state;
    slot_nx    = slot;
    tmr_nx     = tmr;
    dcnt_nx    = dcnt;
    score_nx   = score;
    overrun_nx = overrun_cnt;
    terr_nx    = timeout_err;

    case (state)
      S_TITLE: if (start_rise) state_nx = S_CLEAR;
      S_CLEAR: begin
        score_nx = '0;
        state_nx = S_WAIT;
      end
      S_WAIT: if (tick) begin
        state_nx = S_UPD;
        slot_nx  = '0;
        tmr_nx   = '0;
      end
      S_UPD: begin
        tmr_nx = tmr + TMR_W'(1);
        // An ack arriving on the final timeout cycle still counts as a clean update.
        if (update_done[slot] || tmr == TMR_W'(TIMEOUT)) begin
          if (!update_done[slot]) terr_nx[slot] = 1'b1;
          tmr_nx = '0;
          if (slot == SLOT_W'(N_SLOT - 1)) state_nx = S_CHECK;
          else                             slot_nx  = slot + SLOT_W'(1);
        end
        if (tick && overrun_cnt != 8'hFF) overrun_nx = overrun_cnt + 8'd1;
      end
      S_CHECK: begin
        if (tick && overrun_cnt != 8'hFF) overrun_nx = overrun_cnt + 8'd1;
        if (dead_in) begin
          state_nx = S_DEAD;
          dcnt_nx  = '0;
        end else begin
          if (score != '1) score_nx = score + SCORE_W'(1);
          state_nx = S_WAIT;
        end
      end
      S_DEAD: begin
        if (dcnt == DCNT_W'(DEAD_FRAMES)) state_nx = S_TITLE;
        else if (tick)                    dcnt_nx  = dcnt + DCNT_W'(1);
      end
      default: state_nx = S_TITLE;
    endcase

    req_nx  = (state_nx == S_UPD) ? (N_SLOT'(1) << slot_nx) : '0;
    soft_nx = (state_nx == S_CLEAR);
    case (state_nx)
      S_TITLE: mode_nx = TITLE;
      S_DEAD:  mode_nx = DEAD;
      default: mode_nx = PLAY;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= S_TITLE;
      slot        <= '0;
      tmr         <= '0;
      dcnt        <= '0;
      score       <= '0;
      overrun_cnt <= '0;
      timeout_err <= '0;
      update_req  <= '0;
      soft_reset  <= 1'b0;
      game_state  <= TITLE;
    end else begin
      state       <= state_nx;
      slot        <= slot_nx;
      tmr         <= tmr_nx;
      dcnt        <= dcnt_nx;
      score       <= score_nx;
      overrun_cnt <= overrun_nx;
      timeout_err <= terr_nx;
      update_req  <= req_nx;
      soft_reset  <= soft_nx;
      game_state  <= mode_nx;
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: randomized slot ack latencies, expected request runs,
// score, timeout and overrun figures come from a frame-level model of the game rules.
module tb_game_sequencer;
  import game_pkg::*;

  localparam int N_SLOT      = 4;
  localparam int TIMEOUT     = 15;
  localparam int DEAD_FRAMES = 4;
  localparam int SCORE_W     = 16;
  localparam int NEVER       = 1000;

  logic               clk       = 1'b0;
  logic               rst_n     = 1'b0;
  logic               frame_clk = 1'b1;
  logic               start_key = 1'b0;
  logic               dead_in   = 1'b0;
  logic [N_SLOT-1:0]  update_done = '0;
  logic [N_SLOT-1:0]  update_req;
  logic               soft_reset;
  mode_t              game_state;
  logic [SCORE_W-1:0] score;
  logic [7:0]         overrun_cnt;
  logic [N_SLOT-1:0]  timeout_err;

  game_sequencer #(
    .N_SLOT(N_SLOT), .TIMEOUT(TIMEOUT), .DEAD_FRAMES(DEAD_FRAMES), .SCORE_W(SCORE_W)
  ) dut (
    .Clk(clk), .Reset_n(rst_n), .frame_clk(frame_clk), .start_key(start_key),
    .dead_in(dead_in), .update_done(update_done), .update_req(update_req),
    .soft_reset(soft_reset), .game_state(game_state), .score(score),
    .overrun_cnt(overrun_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Frame-level model state
  int               lat[N_SLOT];
  int               hi_cnt[N_SLOT];
  int               score_m = 0;
  int               ovr_m   = 0;
  logic [N_SLOT-1:0] terr_m = '0;

  // Entity responder: ack a requested slot lat cycles after its request appears;
  // unrequested slots see random done noise that must be ignored.
  always @(negedge clk) begin
    for (int s = 0; s < N_SLOT; s++) begin
      if (update_req[s]) hi_cnt[s]++;
      else               hi_cnt[s] = 0;
      update_done[s] = update_req[s] ? (hi_cnt[s] > lat[s]) : ($urandom_range(0, 1) == 1);
    end
  end

  typedef struct {
    logic [N_SLOT-1:0] v;
    int                len;
  } seg_t;

  seg_t              segs[$];
  logic [N_SLOT-1:0] cur_v    = '0;
  int                cur_len  = 0;
  int                soft_cnt = 0;
  int                dead_req = 0;
  int                bad_req  = 0;

  // Record each run of a constant non-zero request as (value, length).
  always @(negedge clk) begin : mon
    seg_t sg;
    if (update_req !== cur_v) begin
      if (cur_v != '0) begin
        sg.v   = cur_v;
        sg.len = cur_len;
        segs.push_back(sg);
      end
      cur_v   = update_req;
      cur_len = 1;
    end else begin
      cur_len++;
    end
    if (soft_reset) soft_cnt++;
    if (update_req != '0 && !$onehot(update_req)) bad_req++;
    if (game_state == DEAD && update_req != '0) dead_req++;
  end

  task automatic vs_pulse();
    @(negedge clk) frame_clk = 1'b0;
    @(negedge clk) frame_clk = 1'b1;
  endtask

  task automatic run_frame(input bit die, input int ovr_at);
    int n;
    int exp_len;
    segs.delete();
    dead_in = die;
    @(negedge clk) frame_clk = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      frame_clk = 1'b1;
    end while (update_req == '0 && n < 10);
    check("tick_to_req", n, 2);
    n = 0;
    while (update_req != '0 && n < 400) begin
      @(negedge clk);
      n++;
      frame_clk = !(ovr_at > 0 && n == ovr_at);
    end
    check("frame_end", update_req, 0);
    repeat (2) @(negedge clk);
    dead_in = 1'b0;
    check("seg_count", segs.size(), N_SLOT);
    for (int s = 0; s < N_SLOT; s++) begin
      exp_len = (lat[s] > TIMEOUT) ? TIMEOUT + 1 : lat[s] + 1;
      if (lat[s] > TIMEOUT) terr_m[s] = 1'b1;
      if (s < int'(segs.size())) begin
        check($sformatf("req_val%0d", s), segs[s].v, 1 << s);
        check($sformatf("req_len%0d", s), segs[s].len, exp_len);
      end
    end
    if (ovr_at > 0 && ovr_m < 255) ovr_m++;
    if (!die && score_m < 65535) score_m++;
    check("score", score, score_m);
    check("timeout_err", timeout_err, terr_m);
    check("overrun_cnt", overrun_cnt, ovr_m);
    check("frame_mode", game_state, die ? DEAD : PLAY);
  endtask

  task automatic start_game(input bit with_tick);
    soft_cnt = 0;
    segs.delete();
    @(negedge clk);
    start_key = 1'b1;
    if (with_tick) frame_clk = 1'b0;
    @(negedge clk) frame_clk = 1'b1;
    repeat (8) @(negedge clk);
    start_key = 1'b0;
    score_m = 0;
    check("soft_pulse", soft_cnt, 1);
    check("start_mode", game_state, PLAY);
    check("start_score", score, 0);
    check("start_no_frame", (segs.size() != 0 || cur_v != '0), 0);
  endtask

  task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
  endtask

  initial begin
    int n;
    int ovr;
    repeat (3) @(negedge clk);
    check("rst_req", update_req, 0);
    check("rst_mode", game_state, TITLE);
    check("rst_score", score, 0);
    check("rst_ovr", overrun_cnt, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_soft", soft_reset, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // A tick in TITLE starts nothing.
    segs.delete();
    vs_pulse();
    repeat (6) @(negedge clk);
    check("title_no_req", (segs.size() != 0 || cur_v != '0), 0);
    check("title_mode", game_state, TITLE);

    start_game(1'b0);

    set_lat(3, 3, 3, 3);
    for (int f = 0; f < 10; f++) run_frame(1'b0, 0);
    check("ten_frames_score", score, 10);

    set_lat(3, 3, NEVER, 3);
    run_frame(1'b0, 0);
    check("timeout_slot2", timeout_err, 4'b0100);

    set_lat(3, 12, 3, 3);
    run_frame(1'b0, 6);
    check("overrun_one", overrun_cnt, 1);
    set_lat(2, 2, 2, 2);
    run_frame(1'b0, 0);

    for (int f = 0; f < 12; f++) begin
      for (int s = 0; s < N_SLOT; s++) lat[s] = int'($urandom_range(0, 10));
      if ($urandom_range(0, 3) == 0) lat[$urandom_range(0, N_SLOT - 1)] = NEVER;
      ovr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_frame(1'b0, ovr);
    end

    // Death: start_key ignored, DEAD_FRAMES ticks back to TITLE, score held.
    set_lat(2, 2, 2, 2);
    run_frame(1'b1, 0);
    @(negedge clk) start_key = 1'b1;
    repeat (4) @(negedge clk);
    start_key = 1'b0;
    repeat (2) @(negedge clk);
    check("dead_ignores_start", game_state, DEAD);
    for (int k = 1; k <= DEAD_FRAMES; k++) begin
      vs_pulse();
      if (k < DEAD_FRAMES) begin
        repeat (6) @(negedge clk);
        check($sformatf("dead_after_%0d", k), game_state, DEAD);
      end
    end
    n = 0;
    while (game_state != TITLE && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("dead_to_title", game_state, TITLE);
    check("dead_score_held", score, score_m);
    check("dead_no_req", dead_req, 0);

    // Start and tick together: start wins, the tick is dropped.
    start_game(1'b1);
    set_lat(1, 1, 1, 1);
    run_frame(1'b0, 0);

    // Reset in the middle of a slot update aborts immediately.
    set_lat(10, 10, 10, 10);
    vs_pulse();
    repeat (5) @(negedge clk);
    check("pre_reset_busy", (update_req != '0), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_req", update_req, 0);
    check("mid_rst_mode", game_state, TITLE);
    check("mid_rst_score", score, 0);
    check("mid_rst_ovr", overrun_cnt, 0);
    check("mid_rst_terr", timeout_err, 0);
    check("mid_rst_soft", soft_reset, 0);
    @(negedge clk) rst_n = 1'b1;
    score_m = 0;
    ovr_m   = 0;
    terr_m  = '0;
    repeat (3) @(negedge clk);
    check("post_rst_mode", game_state, TITLE);
    start_game(1'b0);
    set_lat(1, 0, 2, 1);
    run_frame(1'b0, 0);

    check("onehot_req", bad_req, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
